l0_access_sequencer: RTL and testbench

Control sequencer for the Conv1D datapath. It drives the L0 status, data-ready and index-reset signals that the memory/L0 index generator consumes. It walks every output tile and, within each, every weight tile through the phases index reset, weight fill, input fill, partial-sum fill, compute and drain. A single Start pulse runs the whole convolution, and a Done pulse ends it.

---
 rtl/conv1d_ctrl_pkg.sv | 32 +++
 rtl/l0_access_sequencer_if.sv | 54 +++++
 rtl/l0_access_sequencer_phase_counter.sv | 30 +++
 rtl/l0_access_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_l0_access_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv1d_ctrl_pkg.sv
// Shared definitions for the Conv1D L0 control path.
// Holds the sequencer state encoding, the L0 status codes and a width helper
// used to size the phase counter.
package conv1d_ctrl_pkg;

    // Sequencer phases, walked once per (output tile, weight tile) pair.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IDX_RST = 3'd1,
        FILL_W  = 3'd2,
        FILL_I  = 3'd3,
        FILL_O  = 3'd4,
        COMPUTE = 3'd5,
        DRAIN   = 3'd6,
        DONE    = 3'd7
    } state_e;

    // L0 buffer status codes seen by the index generator.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_FILL  = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;
    localparam logic [1:0] ST_DRAIN = 2'b11;

    // Bits needed to hold any value in 0..max_value (at least one bit).
    function automatic int width_for(input int max_value);
        if (max_value < 2) begin
            return 1;
        end
        return $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/l0_access_sequencer_if.sv
// Control bundle between the L0 access sequencer and its consumers.
// The master side (memory controller / bench) drives Start and Stall; the
// slave side (the sequencer) drives all status, strobe and index-reset lines.
//
// Handshake: Start is a single-cycle request, accepted only on a rising edge
// where the sequencer is IDLE and Stall is low; it is ignored otherwise.
// Stall is a level: while it is high the sequencer holds its state and phase
// count, statuses read 00 and L0_Data_Is_Ready reads 0; index resets are
// never masked.
interface l0_access_sequencer_if #(
    parameter int WT_W = 2,
    parameter int OT_W = 1
);
    import conv1d_ctrl_pkg::*;

    logic            Start;
    logic            Stall;
    logic [1:0]      L0_Weight_Status;
    logic [1:0]      L0_Input_Status;
    logic [1:0]      L0_Output_Status;
    logic            L0_Data_Is_Ready;
    logic            Mem_Weight_Index_Reset;
    logic            Mem_Input_Index_Reset;
    logic            Mem_Output_Index_Reset;
    logic            L0_Weight_Index_Reset;
    logic            L0_Input_Index_Reset;
    logic            L0_Output_Index_Reset;
    logic [WT_W-1:0] Weight_Tile_Index;
    logic [OT_W-1:0] Output_Tile_Index;
    logic            Busy;
    logic            Done;
    state_e          state;

    modport master (
        output Start, Stall,
        input  L0_Weight_Status, L0_Input_Status, L0_Output_Status,
        input  L0_Data_Is_Ready,
        input  Mem_Weight_Index_Reset, Mem_Input_Index_Reset, Mem_Output_Index_Reset,
        input  L0_Weight_Index_Reset, L0_Input_Index_Reset, L0_Output_Index_Reset,
        input  Weight_Tile_Index, Output_Tile_Index,
        input  Busy, Done, state
    );

    modport slave (
        input  Start, Stall,
        output L0_Weight_Status, L0_Input_Status, L0_Output_Status,
        output L0_Data_Is_Ready,
        output Mem_Weight_Index_Reset, Mem_Input_Index_Reset, Mem_Output_Index_Reset,
        output L0_Weight_Index_Reset, L0_Input_Index_Reset, L0_Output_Index_Reset,
        output Weight_Tile_Index, Output_Tile_Index,
        output Busy, Done, state
    );

endinterface

// File: rtl/l0_access_sequencer_phase_counter.sv
// Loadable down-counter that times each sequencer phase.
// It is reloaded with (phase length - 1) on every phase entry, counts down
// while enabled and flags terminal count when it sits at zero.
module phase_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_value,
    output logic         tc
);

    logic [W-1:0] count;

    // Reload on phase entry, otherwise count down to zero while enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/l0_access_sequencer.sv
// L0 access sequencer for the Conv1D datapath.
// Walks every output tile and, inside it, every weight tile through the
// phases index reset, weight fill, input fill, psum fill, compute and drain.
// Outputs are Moore-decoded from the registered state and tile counters; the
// only combinational input path is Stall masking of statuses and the compute
// strobe.
module l0_access_sequencer
    import conv1d_ctrl_pkg::*;
#(
    parameter int Weight_Nums    = 4,
    parameter int Output_Nums    = 8,
    parameter int L0_Weight_Nums = 2,
    parameter int L0_Output_Nums = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    l0_access_sequencer_if.slave   bus
);

    // Inputs resident per tile follow from the convolution window overlap.
    localparam int L0_Input_Nums = L0_Output_Nums + L0_Weight_Nums - 1;
    localparam int WT_TILES      = Weight_Nums / L0_Weight_Nums;
    localparam int OT_TILES      = Output_Nums / L0_Output_Nums;
    localparam int WT_W          = $clog2(WT_TILES) + 1;
    localparam int OT_W          = $clog2(OT_TILES) + 1;
    localparam int COMPUTE_LEN   = L0_Output_Nums * L0_Weight_Nums;
    localparam int CNT_MAX       = (COMPUTE_LEN > L0_Input_Nums) ? COMPUTE_LEN : L0_Input_Nums;
    localparam int CW            = width_for(CNT_MAX);

    state_e          state;
    state_e          state_next;
    logic [CW-1:0]   load_value;
    logic            load;
    logic            tc;
    logic            advance;
    logic [WT_W-1:0] wt;
    logic [OT_W-1:0] ot;
    logic            last_wt;
    logic            last_ot;

    logic [1:0]      w_st;
    logic [1:0]      i_st;
    logic [1:0]      o_st;
    logic            rdy;
    logic [2:0]      mem_rst;
    logic [2:0]      l0_rst;

    assign last_wt = (wt == WT_W'(WT_TILES - 1));
    assign last_ot = (ot == OT_W'(OT_TILES - 1));
    assign advance = !bus.Stall && tc;
    // Every state change starts a new phase, so the counter reloads then.
    assign load    = (state_next != state);

    // Next phase: leave the current one only when its count expires unstalled.
    always_comb begin
        state_next = state;
        if (!bus.Stall) begin
            case (state)
                IDLE:    if (bus.Start) state_next = IDX_RST;
                IDX_RST: if (tc) state_next = FILL_W;
                FILL_W:  if (tc) state_next = FILL_I;
                FILL_I:  if (tc) state_next = FILL_O;
                FILL_O:  if (tc) state_next = COMPUTE;
                COMPUTE: if (tc) state_next = DRAIN;
                DRAIN:   if (tc) state_next = (last_wt && last_ot) ? DONE : IDX_RST;
                DONE:    if (tc) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Length-1 of the phase being entered; single-cycle phases load zero.
    always_comb begin
        load_value = '0;
        case (state_next)
            FILL_W:  load_value = CW'(L0_Weight_Nums - 1);
            FILL_I:  load_value = CW'(L0_Input_Nums - 1);
            FILL_O:  load_value = CW'(L0_Output_Nums - 1);
            COMPUTE: load_value = CW'(COMPUTE_LEN - 1);
            DRAIN:   load_value = CW'(L0_Output_Nums - 1);
            default: load_value = '0;
        endcase
    end

    phase_counter #(
        .W (CW)
    ) u_phase_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .en         (!bus.Stall),
        .load_value (load_value),
        .tc         (tc)
    );

    // State register; reset wins over any coincident Start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Tile walk: weight tile is the inner loop, both wrap to 0 at the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            wt <= '0;
            ot <= '0;
        end else if ((state == DRAIN) && advance) begin
            if (last_wt) begin
                wt <= '0;
                if (last_ot) begin
                    ot <= '0;
                end else begin
                    ot <= ot + 1'b1;
                end
            end else begin
                wt <= wt + 1'b1;
            end
        end
    end

    // Per-phase status/strobe/reset decode, with statuses and strobe masked by Stall.
    always_comb begin
        w_st    = ST_IDLE;
        i_st    = ST_IDLE;
        o_st    = ST_IDLE;
        rdy     = 1'b0;
        mem_rst = 3'b000;
        l0_rst  = 3'b000;
        case (state)
            IDLE: begin
                mem_rst = 3'b111;
                l0_rst  = 3'b111;
            end
            IDX_RST: begin
                l0_rst = 3'b111;
            end
            FILL_W: begin
                w_st = ST_FILL;
            end
            FILL_I: begin
                w_st = ST_HOLD;
                i_st = ST_FILL;
            end
            FILL_O: begin
                w_st = ST_HOLD;
                i_st = ST_HOLD;
                o_st = ST_FILL;
            end
            COMPUTE: begin
                w_st = ST_HOLD;
                i_st = ST_HOLD;
                o_st = ST_HOLD;
                rdy  = 1'b1;
            end
            DRAIN: begin
                w_st = ST_HOLD;
                i_st = ST_HOLD;
                o_st = ST_DRAIN;
            end
            DONE: begin
                mem_rst = 3'b111;
            end
            default: begin
                w_st = ST_IDLE;
            end
        endcase
        if (bus.Stall) begin
            w_st = ST_IDLE;
            i_st = ST_IDLE;
            o_st = ST_IDLE;
            rdy  = 1'b0;
        end
    end

    assign bus.L0_Weight_Status       = w_st;
    assign bus.L0_Input_Status        = i_st;
    assign bus.L0_Output_Status       = o_st;
    assign bus.L0_Data_Is_Ready       = rdy;
    assign bus.Mem_Weight_Index_Reset = mem_rst[2];
    assign bus.Mem_Input_Index_Reset  = mem_rst[1];
    assign bus.Mem_Output_Index_Reset = mem_rst[0];
    assign bus.L0_Weight_Index_Reset  = l0_rst[2];
    assign bus.L0_Input_Index_Reset   = l0_rst[1];
    assign bus.L0_Output_Index_Reset  = l0_rst[0];
    assign bus.Weight_Tile_Index      = wt;
    assign bus.Output_Tile_Index      = ot;
    assign bus.Busy                   = (state != IDLE);
    assign bus.Done                   = (state == DONE);
    assign bus.state                  = state;

endmodule

// File: tb/tb_l0_access_sequencer.sv
// Bench for l0_access_sequencer: two instances (2-tile and 4-tile configs),
// a cycle-level expected trace built from the phase table, random stalls.
module tb_l0_access_sequencer;
    import conv1d_ctrl_pkg::*;

    localparam int W      = 23;
    localparam int LWN    = 2;
    localparam int LON    = 8;
    localparam int LIN    = LON + LWN - 1;
    localparam int WTILES = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic stall = 1'b0;
    int   sel   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    l0_access_sequencer_if #(.WT_W(2), .OT_W(1)) bus_a ();
    l0_access_sequencer_if #(.WT_W(2), .OT_W(2)) bus_b ();

    assign bus_a.Start = start;
    assign bus_a.Stall = stall;
    assign bus_b.Start = start;
    assign bus_b.Stall = stall;

    l0_access_sequencer #(
        .Weight_Nums(4), .Output_Nums(8), .L0_Weight_Nums(2), .L0_Output_Nums(8)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    l0_access_sequencer #(
        .Weight_Nums(4), .Output_Nums(16), .L0_Weight_Nums(2), .L0_Output_Nums(8)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Packed view: ws[22:21] is[20:19] os[18:17] rdy[16] mem[15:13] l0[12:10]
    // wt[9:6] ot[5:2] busy[1] done[0]
    function automatic logic [W-1:0] mk(input logic [1:0] ws, input logic [1:0] is,
                                        input logic [1:0] os, input logic rdy,
                                        input logic [2:0] mem, input logic [2:0] l0,
                                        input logic [3:0] wt, input logic [3:0] ot,
                                        input logic busy, input logic done);
        return {ws, is, os, rdy, mem, l0, wt, ot, busy, done};
    endfunction

    function automatic logic [W-1:0] idle_vec();
        return mk(2'b00, 2'b00, 2'b00, 1'b0, 3'b111, 3'b111, 4'd0, 4'd0, 1'b0, 1'b0);
    endfunction

    logic [W-1:0] obs_a;
    logic [W-1:0] obs_b;
    logic [W-1:0] obs;

    assign obs_a = mk(bus_a.L0_Weight_Status, bus_a.L0_Input_Status, bus_a.L0_Output_Status,
                      bus_a.L0_Data_Is_Ready,
                      {bus_a.Mem_Weight_Index_Reset, bus_a.Mem_Input_Index_Reset, bus_a.Mem_Output_Index_Reset},
                      {bus_a.L0_Weight_Index_Reset, bus_a.L0_Input_Index_Reset, bus_a.L0_Output_Index_Reset},
                      {2'b00, bus_a.Weight_Tile_Index}, {3'b000, bus_a.Output_Tile_Index},
                      bus_a.Busy, bus_a.Done);
    assign obs_b = mk(bus_b.L0_Weight_Status, bus_b.L0_Input_Status, bus_b.L0_Output_Status,
                      bus_b.L0_Data_Is_Ready,
                      {bus_b.Mem_Weight_Index_Reset, bus_b.Mem_Input_Index_Reset, bus_b.Mem_Output_Index_Reset},
                      {bus_b.L0_Weight_Index_Reset, bus_b.L0_Input_Index_Reset, bus_b.L0_Output_Index_Reset},
                      {2'b00, bus_b.Weight_Tile_Index}, {2'b00, bus_b.Output_Tile_Index},
                      bus_b.Busy, bus_b.Done);
    assign obs = (sel == 0) ? obs_a : obs_b;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur;

    // Expand a whole run into its per-cycle expected outputs.
    task automatic gen_run(input int otiles);
        for (int o = 0; o < otiles; o++) begin
            for (int w = 0; w < WTILES; w++) begin
                exp_q.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 3'b111, 4'(w), 4'(o), 1'b1, 1'b0));
                repeat (LWN) exp_q.push_back(mk(2'b01, 2'b00, 2'b00, 1'b0, 3'b000, 3'b000, 4'(w), 4'(o), 1'b1, 1'b0));
                repeat (LIN) exp_q.push_back(mk(2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 3'b000, 4'(w), 4'(o), 1'b1, 1'b0));
                repeat (LON) exp_q.push_back(mk(2'b10, 2'b10, 2'b01, 1'b0, 3'b000, 3'b000, 4'(w), 4'(o), 1'b1, 1'b0));
                repeat (LON * LWN) exp_q.push_back(mk(2'b10, 2'b10, 2'b10, 1'b1, 3'b000, 3'b000, 4'(w), 4'(o), 1'b1, 1'b0));
                repeat (LON) exp_q.push_back(mk(2'b10, 2'b10, 2'b11, 1'b0, 3'b000, 3'b000, 4'(w), 4'(o), 1'b1, 1'b0));
            end
        end
        exp_q.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 3'b111, 3'b000, 4'd0, 4'd0, 1'b1, 1'b1));
    endtask

    // Advance the model one cycle per edge: reset, stall-hold, start, or step.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_q.delete();
                cur = idle_vec();
            end else if (!stall) begin
                if (!cur[1]) begin
                    if (start) begin
                        gen_run((sel != 0) ? 2 : 1);
                        cur = exp_q.pop_front();
                    end
                end else if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                end else begin
                    cur = idle_vec();
                end
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    int         done_cnt = 0;
    int         rdy_cnt  = 0;
    int         fi_cnt   = 0;
    logic [3:0] wt_seq[$];
    logic       prev_busy = 1'b0;
    logic [W-1:0] exp_v;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_v = cur;
            if (stall) begin
                exp_v[22:17] = 6'b0;
                exp_v[16]    = 1'b0;
            end
            check("trace", 64'(obs), 64'(exp_v));
            if (obs[0]) done_cnt++;
            if (obs[16]) rdy_cnt++;
            if (obs[20:19] == 2'b01) fi_cnt++;
            if (obs[1] && (!prev_busy || (wt_seq.size() == 0) || (wt_seq[$] != obs[9:6])))
                wt_seq.push_back(obs[9:6]);
            prev_busy = obs[1];
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+2. Pulses Start, then waits for Done while driving
    // Stall/Start per mode. lat counts cycles after the Start edge.
    task automatic do_run(input int mode, output int lat, output int nst);
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        lat = 0;
        nst = 0;
        while (lat < 400) begin
            @(negedge clk);
            lat++;
            if (((sel == 0) ? bus_a.Done : bus_b.Done) == 1'b1) break;
            @(posedge clk);
            #2;
            case (mode)
                1:       stall = (lat + 1 >= 6) && (lat + 1 <= 8);
                2:       stall = (lat + 1 <= 60) && ($urandom_range(0, 3) == 0);
                default: stall = 1'b0;
            endcase
            if (stall) nst++;
            start = (mode == 3) && (lat + 1 == 25);
        end
        @(posedge clk);
        #2;
        stall = 1'b0;
        start = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #2;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int nst;
        int b_done;
        int b_rdy;
        int b_fi;
        int b_seq;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state_a", 64'(bus_a.state), 64'(IDLE));
        check("rst_state_b", 64'(bus_b.state), 64'(IDLE));
        check("rst_busy", 64'(bus_a.Busy), 64'd0);
        check("rst_done", 64'(bus_a.Done), 64'd0);
        check("rst_rdy", 64'(bus_a.L0_Data_Is_Ready), 64'd0);
        check("rst_status", 64'(obs_a[22:17]), 64'd0);
        check("rst_idx_resets", 64'(obs_a[15:10]), 64'h3f);
        check("rst_tiles", 64'(obs_a[9:2]), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Plain run with the default config.
        b_done = done_cnt; b_rdy = rdy_cnt; b_fi = fi_cnt; b_seq = wt_seq.size();
        do_run(0, lat, nst);
        check("lat_plain", 64'(lat), 64'd89);
        settle();
        check("done_pulses_plain", 64'(done_cnt - b_done), 64'd1);
        check("rdy_cycles_plain", 64'(rdy_cnt - b_rdy), 64'd32);
        check("fill_i_cycles_plain", 64'(fi_cnt - b_fi), 64'd18);
        check("wt_seq_len", 64'(wt_seq.size() - b_seq), 64'd3);
        if (wt_seq.size() - b_seq == 3) begin
            check("wt_seq_0", 64'(wt_seq[b_seq]), 64'd0);
            check("wt_seq_1", 64'(wt_seq[b_seq + 1]), 64'd1);
            check("wt_seq_2", 64'(wt_seq[b_seq + 2]), 64'd0);
        end

        // Three stalled cycles inside FILL_I of tile 0.
        b_fi = fi_cnt; b_rdy = rdy_cnt;
        do_run(1, lat, nst);
        check("lat_fill_i_stall", 64'(lat), 64'd92);
        check("stall_count", 64'(nst), 64'd3);
        settle();
        check("fill_i_cycles_stall", 64'(fi_cnt - b_fi), 64'd18);
        check("rdy_cycles_stall", 64'(rdy_cnt - b_rdy), 64'd32);

        // Start pulsed during COMPUTE is ignored.
        b_done = done_cnt;
        do_run(3, lat, nst);
        check("lat_start_in_compute", 64'(lat), 64'd89);
        settle();
        check("done_pulses_start_in_compute", 64'(done_cnt - b_done), 64'd1);

        // Random stalls: each stalled cycle costs exactly one cycle.
        for (int r = 0; r < 3; r++) begin
            b_done = done_cnt; b_rdy = rdy_cnt;
            do_run(2, lat, nst);
            check("lat_random_stall", 64'(lat), 64'(89 + nst));
            settle();
            check("done_pulses_random", 64'(done_cnt - b_done), 64'd1);
            check("rdy_cycles_random", 64'(rdy_cnt - b_rdy), 64'd32);
        end

        // Reset during DRAIN of tile 1 (cycle 84 of the run).
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (83) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("pre_rst_drain", 64'(obs[18:17]), 64'd3);
        check("pre_rst_wt", 64'(obs[9:6]), 64'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 64'(obs[1]), 64'd0);
        check("post_rst_idx_resets", 64'(obs[15:10]), 64'h3f);
        check("post_rst_tiles", 64'(obs[9:2]), 64'd0);
        check("post_rst_done", 64'(obs[0]), 64'd0);
        @(posedge clk);
        #2;
        do_run(0, lat, nst);
        check("lat_after_rst", 64'(lat), 64'd89);
        settle();

        // Start held while stalled in IDLE: run begins once Stall drops.
        start = 1'b1;
        stall = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        check("idle_stall_busy", 64'(obs[1]), 64'd0);
        check("idle_stall_resets", 64'(obs[15:10]), 64'h3f);
        stall = 1'b0;
        do_run(0, lat, nst);
        check("lat_idle_stall", 64'(lat), 64'd89);
        settle();

        // Switch to the 4-tile instance from a clean reset.
        rst = 1'b1;
        @(posedge clk);
        #2;
        sel = 1;
        rst = 1'b0;
        @(posedge clk);
        #2;
        b_done = done_cnt; b_rdy = rdy_cnt;
        do_run(0, lat, nst);
        check("lat_4tile", 64'(lat), 64'd177);
        settle();
        check("done_pulses_4tile", 64'(done_cnt - b_done), 64'd1);
        check("rdy_cycles_4tile", 64'(rdy_cnt - b_rdy), 64'd64);
        do_run(2, lat, nst);
        check("lat_4tile_random_stall", 64'(lat), 64'(177 + nst));
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
